// File: rtl/layer6_buf_pkg.sv
// -----------------------------------------------------------------------------
// layer6_buf_pkg
// Shared definitions for the layer-6 pixel buffer:
//   - pixel width, lane width and lane count (8 lanes x 16 bit = 128 bit)
//   - pooling window edge length (2x2 windows)
//   - buffer state enumeration (FILL while layer-5 writes, FULL while
//     layer-6 reads)
// No ports; imported by layer6_pixel_buffer and layer6_relu_lane.
// -----------------------------------------------------------------------------
package layer6_buf_pkg;

   localparam int DATA_W = 128;
   localparam int LANE_W = 16;
   localparam int LANE_N = 8;
   localparam int WIN    = 2;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } buf_state_e;

endpackage

// File: rtl/layer6_relu_lane.sv
// -----------------------------------------------------------------------------
// layer6_relu_lane
// One 16-bit lane of the write-side ReLU clamp. When CLAMP_EN is set, a lane
// whose two's-complement sign bit is set is replaced by zero; non-negative
// lanes pass through. With CLAMP_EN clear the lane is a plain wire.
// Ports:
//   lane_in   in  LANE_W  raw lane value from the writer
//   lane_out  out LANE_W  value to be stored
// -----------------------------------------------------------------------------
module layer6_relu_lane
   import layer6_buf_pkg::*;
#(
   parameter bit CLAMP_EN = 1'b0
) (
   input  logic [LANE_W-1:0] lane_in,
   output logic [LANE_W-1:0] lane_out
);

   // Negative values collapse to zero only when clamping is enabled.
   always_comb begin
      lane_out = lane_in;
      if (CLAMP_EN && lane_in[LANE_W-1]) begin
         lane_out = '0;
      end
   end

endmodule

// File: rtl/layer6_pixel_buffer.sv
// -----------------------------------------------------------------------------
// layer6_pixel_buffer
// Feature-map store between the layer-5 writer and the layer-6 2x2 max-pool
// reader. In FILL it accepts row/col addressed pixel writes until all
// IN_WIDTH*IN_WIDTH locations are written, then pulses pixel_store_done for
// one cycle and moves to FULL. In FULL one registered read returns the four
// pixels of the 2x2 window for pooled position (row, col). A pulse on
// layer6_calculation_done releases the map and returns to FILL.
// Optional build macro: LAYER6_BUF_RELU_EN clamps negative 16-bit lanes of
// save_data to zero at write time; without it data is stored bit-exact.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   save_enable/row/col/data         write port from layer-5
//   read_pixel_signal/row/col_addr   window read request from layer-6
//   layer6_calculation_done          pooling finished, release buffer
//   pixel_store_done                 one-cycle pulse when the map is full
//   input_data_{even,odd}_{even,odd} registered 2x2 window pixels
//   buf_error                        sticky protocol-error flag
// -----------------------------------------------------------------------------
module layer6_pixel_buffer
   import layer6_buf_pkg::*;
#(
   parameter int OUT_WIDTH = 8,
   parameter int IN_WIDTH  = 2 * OUT_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              save_enable,
   input  logic [15:0]       save_row,
   input  logic [15:0]       save_col,
   input  logic [DATA_W-1:0] save_data,
   input  logic              read_pixel_signal,
   input  logic [15:0]       read_row_addr,
   input  logic [15:0]       read_col_addr,
   input  logic              layer6_calculation_done,
   output logic              pixel_store_done,
   output logic [DATA_W-1:0] input_data_even_even,
   output logic [DATA_W-1:0] input_data_even_odd,
   output logic [DATA_W-1:0] input_data_odd_even,
   output logic [DATA_W-1:0] input_data_odd_odd,
   output logic              buf_error
);

   localparam int          DEPTH      = IN_WIDTH * IN_WIDTH;
   localparam int          ADDR_W     = $clog2(DEPTH);
   localparam logic [15:0] FULL_COUNT = 16'(DEPTH);

`ifdef LAYER6_BUF_RELU_EN
   localparam bit RELU_EN = 1'b1;
`else
   localparam bit RELU_EN = 1'b0;
`endif

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] wr_data;

   buf_state_e        state_q, state_d;
   logic [15:0]       count_q, count_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] ee_q, ee_d, eo_q, eo_d, oe_q, oe_d, oo_q, oo_d;

   logic              wr_in_range, rd_in_range, wr_accept;
   logic [ADDR_W-1:0] wr_idx, rd_base;

   // Per-lane write-side clamp; a passthrough unless the ReLU build is selected.
   for (genvar g = 0; g < LANE_N; g++) begin : g_lane
      layer6_relu_lane #(.CLAMP_EN(RELU_EN)) u_lane (
         .lane_in  (save_data[g*LANE_W +: LANE_W]),
         .lane_out (wr_data[g*LANE_W +: LANE_W])
      );
   end

   // Address decode: the window base is the even/even corner (2r, 2c); the other
   // three quadrants sit one column and/or one row further on.
   always_comb begin
      wr_in_range = (save_row < 16'(IN_WIDTH)) && (save_col < 16'(IN_WIDTH));
      rd_in_range = (read_row_addr < 16'(OUT_WIDTH)) && (read_col_addr < 16'(OUT_WIDTH));
      wr_accept   = (state_q == FILL) && save_enable && wr_in_range;
      wr_idx      = ADDR_W'(32'(save_row) * IN_WIDTH + 32'(save_col));
      rd_base     = ADDR_W'(32'(read_row_addr) * WIN * IN_WIDTH + 32'(read_col_addr) * WIN);
   end

   // Next-state logic. Quadrant registers hold unless a read is requested;
   // the store-done pulse defaults low so it can never stick.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      done_d  = 1'b0;
      err_d   = err_q;
      ee_d    = ee_q;
      eo_d    = eo_q;
      oe_d    = oe_q;
      oo_d    = oo_q;
      unique case (state_q)
         FILL: begin
            if (save_enable) begin
               if (wr_in_range) begin
                  count_d = count_q + 16'd1;
                  if (count_q + 16'd1 == FULL_COUNT) begin
                     state_d = FULL;
                     done_d  = 1'b1;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
            if (read_pixel_signal) begin
               ee_d  = '0;
               eo_d  = '0;
               oe_d  = '0;
               oo_d  = '0;
               err_d = 1'b1;
            end
         end
         FULL: begin
            if (read_pixel_signal) begin
               if (rd_in_range) begin
                  ee_d = mem[rd_base];
                  eo_d = mem[rd_base + ADDR_W'(1)];
                  oe_d = mem[rd_base + ADDR_W'(IN_WIDTH)];
                  oo_d = mem[rd_base + ADDR_W'(IN_WIDTH + 1)];
               end else begin
                  ee_d  = '0;
                  eo_d  = '0;
                  oe_d  = '0;
                  oo_d  = '0;
                  err_d = 1'b1;
               end
            end
            if (save_enable) begin
               err_d = 1'b1;
            end
            if (layer6_calculation_done) begin
               state_d = FILL;
               count_d = '0;
            end
         end
      endcase
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FILL;
         count_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ee_q    <= '0;
         eo_q    <= '0;
         oe_q    <= '0;
         oo_q    <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         done_q  <= done_d;
         err_q   <= err_d;
         ee_q    <= ee_d;
         eo_q    <= eo_d;
         oe_q    <= oe_d;
         oo_q    <= oo_d;
      end
   end

   // Storage array: written only in FILL, never cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst && wr_accept) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign pixel_store_done     = done_q;
   assign buf_error            = err_q;
   assign input_data_even_even = ee_q;
   assign input_data_even_odd  = eo_q;
   assign input_data_odd_even  = oe_q;
   assign input_data_odd_odd   = oo_q;

endmodule

// File: tb/tb_layer6_pixel_buffer.sv
// -----------------------------------------------------------------------------
// tb_layer6_pixel_buffer
// Directed bench for layer6_pixel_buffer: fill, streaming window reads,
// table-driven window reads with boundary addresses, protocol errors,
// release/refill and reset in the middle of a fill. Honours
// LAYER6_BUF_RELU_EN for the clamp expectations.
// -----------------------------------------------------------------------------
module tb_layer6_pixel_buffer;
   import layer6_buf_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              save_enable;
   logic [15:0]       save_row, save_col;
   logic [DATA_W-1:0] save_data;
   logic              read_pixel_signal;
   logic [15:0]       read_row_addr, read_col_addr;
   logic              layer6_calculation_done;
   logic              pixel_store_done;
   logic [DATA_W-1:0] input_data_even_even, input_data_even_odd;
   logic [DATA_W-1:0] input_data_odd_even, input_data_odd_odd;
   logic              buf_error;

   int check_count = 0;
   int error_count = 0;
   int pulse_count = 0;

   typedef struct {
      logic [15:0] r;
      logic [15:0] c;
      logic [15:0] ee;
      logic [15:0] eo;
      logic [15:0] oe;
      logic [15:0] oo;
   } win_vec_t;

   win_vec_t vecs [7];

   layer6_pixel_buffer dut (
      .clk                     (clk),
      .rst                     (rst),
      .save_enable             (save_enable),
      .save_row                (save_row),
      .save_col                (save_col),
      .save_data               (save_data),
      .read_pixel_signal       (read_pixel_signal),
      .read_row_addr           (read_row_addr),
      .read_col_addr           (read_col_addr),
      .layer6_calculation_done (layer6_calculation_done),
      .pixel_store_done        (pixel_store_done),
      .input_data_even_even    (input_data_even_even),
      .input_data_even_odd     (input_data_even_odd),
      .input_data_odd_even     (input_data_odd_even),
      .input_data_odd_odd      (input_data_odd_odd),
      .buf_error               (buf_error)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Count store-done pulses on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (pixel_store_done) pulse_count++;
   end

   // Reference pixel pattern: every lane carries base + row*16 + col.
   function automatic logic [DATA_W-1:0] pix(input int r, input int c, input int base);
      logic [15:0] v;
      v = 16'(base + r * 16 + c);
      return {LANE_N{v}};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One comparison: bumps the counters and reports a failure line.
   task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                              input logic [DATA_W-1:0] exp);
      check_count++;
      if (act !== exp) begin
         error_count++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs and advance past the following rising edge.
   task automatic applyStimulus(input logic se, input logic [15:0] sr, input logic [15:0] sc,
                                input logic [DATA_W-1:0] sd, input logic rd,
                                input logic [15:0] rr, input logic [15:0] rc,
                                input logic calc);
      save_enable             = se;
      save_row                = sr;
      save_col                = sc;
      save_data               = sd;
      read_pixel_signal       = rd;
      read_row_addr           = rr;
      read_col_addr           = rc;
      layer6_calculation_done = calc;
      step();
   endtask

   task automatic idle();
      applyStimulus(1'b0, 16'd0, 16'd0, '0, 1'b0, 16'd0, 16'd0, 1'b0);
   endtask

   // Write all 256 locations; the pulse must appear right after write 256.
   task automatic fillMap(input int base, input bit special_zero);
      logic [DATA_W-1:0] d;
      for (int idx = 0; idx < 256; idx++) begin
         d = pix(idx / 16, idx % 16, base);
         if (special_zero && idx == 0) begin
            d = {{6{16'h1234}}, 16'h7FFF, 16'h8001};
         end
         applyStimulus(1'b1, 16'(idx / 16), 16'(idx % 16), d, 1'b0, 16'd0, 16'd0, 1'b0);
         if (idx == 254) checkOutput("store_done_early", 128'(pixel_store_done), 128'd0);
         if (idx == 255) checkOutput("store_done_pulse", 128'(pixel_store_done), 128'd1);
      end
      idle();
      checkOutput("store_done_width", 128'(pixel_store_done), 128'd0);
   endtask

   task automatic checkWindow(input string name, input logic [15:0] ee, input logic [15:0] eo,
                              input logic [15:0] oe, input logic [15:0] oo);
      checkOutput({name, "_ee"}, input_data_even_even, {LANE_N{ee}});
      checkOutput({name, "_eo"}, input_data_even_odd,  {LANE_N{eo}});
      checkOutput({name, "_oe"}, input_data_odd_even,  {LANE_N{oe}});
      checkOutput({name, "_oo"}, input_data_odd_odd,   {LANE_N{oo}});
   endtask

   initial begin
      int pulses_before;
      logic [15:0] relu_lane0;

      vecs[0] = '{16'd0, 16'd0, 16'h0000, 16'h0001, 16'h0010, 16'h0011};
      vecs[1] = '{16'd3, 16'd5, 16'h006A, 16'h006B, 16'h007A, 16'h007B};
      vecs[2] = '{16'd7, 16'd7, 16'h00EE, 16'h00EF, 16'h00FE, 16'h00FF};
      vecs[3] = '{16'd2, 16'd6, 16'h004C, 16'h004D, 16'h005C, 16'h005D};
      vecs[4] = '{16'd8, 16'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      vecs[5] = '{16'd0, 16'd8, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      vecs[6] = '{16'd7, 16'd0, 16'h00E0, 16'h00E1, 16'h00F0, 16'h00F1};

      // Reset and check reset values.
      rst = 1'b1;
      idle();
      idle();
      rst = 1'b0;
      checkOutput("reset_done", 128'(pixel_store_done), 128'd0);
      checkOutput("reset_err", 128'(buf_error), 128'd0);
      checkWindow("reset_win", 16'h0, 16'h0, 16'h0, 16'h0);

      // First fill.
      pulses_before = pulse_count;
      fillMap(0, 1'b0);
      idle();
      checkOutput("fill1_pulse_count", 128'(pulse_count - pulses_before), 128'd1);
      checkOutput("fill1_err", 128'(buf_error), 128'd0);

      // Streaming reads on 64 consecutive cycles, each window one cycle later.
      for (int k = 0; k < 64; k++) begin
         applyStimulus(1'b0, 16'd0, 16'd0, '0, 1'b1, 16'(k / 8), 16'(k % 8), 1'b0);
         checkOutput($sformatf("stream%0d_ee", k), input_data_even_even, pix(2 * (k / 8), 2 * (k % 8), 0));
         checkOutput($sformatf("stream%0d_oo", k), input_data_odd_odd, pix(2 * (k / 8) + 1, 2 * (k % 8) + 1, 0));
      end

      // Outputs hold while no read is requested.
      idle();
      checkOutput("hold_ee", input_data_even_even, pix(14, 14, 0));
      checkOutput("hold_oo", input_data_odd_odd, pix(15, 15, 0));
      checkOutput("stream_err", 128'(buf_error), 128'd0);

      // Write in FULL: dropped, error raised.
      applyStimulus(1'b1, 16'd0, 16'd0, {DATA_W{1'b1}}, 1'b0, 16'd0, 16'd0, 1'b0);
      checkOutput("full_write_err", 128'(buf_error), 128'd1);

      // Table-driven window reads, including out-of-range addresses.
      foreach (vecs[i]) begin
         applyStimulus(1'b0, 16'd0, 16'd0, '0, 1'b1, vecs[i].r, vecs[i].c, 1'b0);
         checkWindow($sformatf("vec%0d", i), vecs[i].ee, vecs[i].eo, vecs[i].oe, vecs[i].oo);
      end

      // Release with a read in the same cycle; the read is still served.
      applyStimulus(1'b0, 16'd0, 16'd0, '0, 1'b1, 16'd1, 16'd1, 1'b1);
      checkWindow("release_read", 16'h0022, 16'h0023, 16'h0032, 16'h0033);

      // Read in FILL returns zeros.
      applyStimulus(1'b0, 16'd0, 16'd0, '0, 1'b1, 16'd0, 16'd0, 1'b0);
      checkWindow("fill_read", 16'h0, 16'h0, 16'h0, 16'h0);

      // Out-of-range write must not count toward the fill.
      applyStimulus(1'b1, 16'd0, 16'd16, pix(0, 0, 16'h3000), 1'b0, 16'd0, 16'd0, 1'b0);
      pulses_before = pulse_count;
      fillMap(16'h1000, 1'b1);
      checkOutput("fill2_pulse_count", 128'(pulse_count - pulses_before), 128'd1);

      // Lane clamp check on location (0,0) of the second fill.
`ifdef LAYER6_BUF_RELU_EN
      relu_lane0 = 16'h0000;
`else
      relu_lane0 = 16'h8001;
`endif
      applyStimulus(1'b0, 16'd0, 16'd0, '0, 1'b1, 16'd0, 16'd0, 1'b0);
      checkOutput("relu_ee", input_data_even_even, {{6{16'h1234}}, 16'h7FFF, relu_lane0});
      checkOutput("refill_eo", input_data_even_odd, pix(0, 1, 16'h1000));

      // Release, write 100 pixels, then reset mid-fill.
      applyStimulus(1'b0, 16'd0, 16'd0, '0, 1'b0, 16'd0, 16'd0, 1'b1);
      for (int idx = 0; idx < 100; idx++) begin
         applyStimulus(1'b1, 16'(idx / 16), 16'(idx % 16), pix(0, 0, 16'h2000), 1'b0, 16'd0, 16'd0, 1'b0);
      end
      rst = 1'b1;
      idle();
      rst = 1'b0;
      checkOutput("midreset_err", 128'(buf_error), 128'd0);
      checkOutput("midreset_ee", input_data_even_even, '0);
      pulses_before = pulse_count;
      fillMap(16'h2000, 1'b0);
      checkOutput("fill3_pulse_count", 128'(pulse_count - pulses_before), 128'd1);
      checkOutput("total_pulses", 128'(pulse_count), 128'd3);

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule

// File: doc/layer6_pixel_buffer.md
Name: layer6_pixel_buffer

Overview:
- Feature-map store between the layer-5 output stage (writer) and the layer-6 2x2 max-pooling stage (reader).
- Accepts row/col-addressed 128-bit pixel writes (8 channels x 16-bit) until the map is full, then pulses pixel_store_done.
- Serves 2x2 pooling windows: one registered read returns all four quadrant pixels for output position (row, col).
- Releases and refills when the pooling stage reports layer6_calculation_done.

Parameters:
- DATA_W, 128, pixel width (8 lanes x 16 bit).
- OUT_WIDTH, 8, pooled output width/height; read address range 0..OUT_WIDTH-1.
- IN_WIDTH, 2*OUT_WIDTH, stored map width/height; write address range 0..IN_WIDTH-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- save_enable  in  1  write strobe from layer-5.
- save_row  in  16  write row.
- save_col  in  16  write col.
- save_data  in  DATA_W  write pixel.
- read_pixel_signal  in  1  read strobe from pooling stage.
- read_row_addr  in  16  pooled output row.
- read_col_addr  in  16  pooled output col.
- layer6_calculation_done  in  1  pooling finished; release buffer.
- pixel_store_done  out  1  one-cycle pulse: map full.
- input_data_even_even  out  DATA_W  mem[2r][2c].
- input_data_even_odd  out  DATA_W  mem[2r][2c+1].
- input_data_odd_even  out  DATA_W  mem[2r+1][2c].
- input_data_odd_odd  out  DATA_W  mem[2r+1][2c+1].
- buf_error  out  1  sticky protocol-error flag.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0, state FILL, write count 0. Memory contents are not cleared.
- Reset mid-operation returns to FILL immediately and discards any pending pulse.
- State FILL:
  - Write accepted when save_enable=1 and save_row<IN_WIDTH and save_col<IN_WIDTH. It stores save_data at [save_row][save_col] and increments the 16-bit write count.
  - Out-of-range write: dropped, buf_error set.
  - Duplicate addresses are counted twice. The writer guarantees one write per location.
  - When an accepted write brings the count to IN_WIDTH*IN_WIDTH: next state FULL; pixel_store_done=1 for exactly the following cycle (first FULL cycle).
  - layer6_calculation_done in FILL is ignored.
  - read_pixel_signal in FILL: quadrant outputs driven 0 on the next cycle; buf_error set.
- State FULL:
  - Read: read_pixel_signal=1 samples r=read_row_addr, c=read_col_addr. The four quadrant outputs update on the next rising edge (latency 1).
  - Outputs hold their last value while read_pixel_signal=0.
  - r>=OUT_WIDTH or c>=OUT_WIDTH: outputs 0 and buf_error set.
  - Back-to-back reads every cycle are supported at full throughput.
  - save_enable in FULL: write dropped, buf_error set.
  - layer6_calculation_done=1: next state FILL, write count cleared. A read in that same cycle is still served.
- pixel_store_done is never held high, so a reader that returns to idle does not restart spuriously.
- buf_error is sticky; only rst clears it.

Optional Feature:
- Macro: LAYER6_BUF_RELU_EN.
- Defined: each 16-bit lane of save_data is clamped to 0 at write time if its sign bit is set (two's complement); non-negative lanes are stored unchanged.
- Undefined: save_data is stored bit-exact.
- Read path is identical in both builds.

Decomposition:
- Shared package layer6_buf_pkg holds:
  - DATA_W, lane width 16, and lane count 8.
  - State enum {FILL, FULL}.
  - Window-size constant (2).
- One sub-module is natural: layer6_relu_lane, a per-lane clamp instantiated 8 times under LAYER6_BUF_RELU_EN.
- The storage array and FSM stay in the top module.

Test Plan:
- Fill: write all 256 locations with data = {8{row*16+col}} -> pixel_store_done pulses exactly once, the cycle after write 256; buf_error=0.
- Window read: in FULL, read r=3,c=5 -> next cycle even_even=pix(6,10), even_odd=pix(6,11), odd_even=pix(7,10), odd_odd=pix(7,11).
- Streaming: reads on 64 consecutive cycles over all (r,c) -> each window appears exactly 1 cycle after its request; no gaps.
- Protocol errors:
  - write in FULL -> memory unchanged, buf_error=1.
  - read r=8 -> outputs 0.
  - write save_col=16 in FILL -> count unchanged.
- Release/refill: layer6_calculation_done in FULL -> FILL next cycle; a second 256-write fill gives a second single pixel_store_done pulse. rst asserted after write 100 -> no pulse until 256 fresh writes.
- LAYER6_BUF_RELU_EN:
  - Defined: write lane value 16'h8001 -> reads back 16'h0000; 16'h7FFF -> reads back unchanged.
  - Undefined: 16'h8001 reads back unchanged.
